seqdet_driver: RTL and testbench
================================

Name: seqdet_driver

Overview:
- Self-test sequencer for the lab board's serial "1011" sequence detector (non-overlapping; match output z is registered and asserts the cycle after the 4th bit is sampled).
- On a start pulse, latches a pattern word and length, pulses the detector's reset, and shifts the pattern into the detector MSB-first, one bit per clk.
- Counts z pulses, records the bit position of the first match, and presents the results to the display logic.

Parameters:
- PAT_W, 16, maximum pattern length in bits.
- LEN_W, 5, width of len and first_idx; must satisfy 2^LEN_W > PAT_W.
- CNT_W, 4, width of match_cnt (saturating).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  run request, sampled in IDLE only.
- pattern  in  PAT_W  bits [len-1:0] are shifted; bit len-1 goes first.
- len  in  LEN_W  number of bits to shift; values >PAT_W clamp to PAT_W; 0 is legal.
- det_z  in  1  detector match output.
- det_x  out  1  serial bit to detector.
- det_rst_n  out  1  detector reset, active-low, registered.
- busy  out  1  high in CLEAR/SHIFT/DRAIN.
- done  out  1  one-cycle pulse in DONE.
- match_cnt  out  CNT_W  z pulses seen in last run, saturating.
- first_idx  out  LEN_W  bits consumed when first z seen; 0 = no match.
- state_out  out  4  zero-padded FSM state code for display.

Behaviour:
- Reset is asynchronous, active-low, clock clk. Reset values:
  - state = IDLE.
  - det_x = 0, det_rst_n = 0.
  - busy = 0, done = 0.
  - match_cnt = 0, first_idx = 0.
  - Internal bit counter = 0, shift register = 0.
- State codes: IDLE=0, CLEAR=1, SHIFT=2, DRAIN=3, DONE=4. Default and illegal codes go to IDLE.
- IDLE: det_rst_n = 1 and det_x = 0.
  - On an edge with start=1, latch pattern and clamped len, clear match_cnt, first_idx and the bit counter, and go to CLEAR.
- CLEAR: lasts exactly 1 cycle with det_rst_n = 0 and det_x = 0. Next state is SHIFT if latched len > 0, else DRAIN.
- SHIFT: det_rst_n = 1; det_x = latched pattern[len-1-k], where k is the bit counter.
  - k increments every cycle.
  - Leave to DRAIN on the edge where k = len-1 (len cycles total).
- DRAIN: lasts exactly 1 cycle with det_x = 0. This captures the z caused by the last bit.
- DONE: lasts exactly 1 cycle with done = 1, then IDLE.
- Counting: in SHIFT and DRAIN, if det_z = 1:
  - match_cnt increments, saturating at 2^CNT_W-1.
  - If first_idx = 0, first_idx is loaded with k. In SHIFT, k is the number of bits already consumed; in DRAIN it is len.
  - det_z is ignored in IDLE, CLEAR and DONE.
- Timing: start is sampled at edge E0; done is high in the cycle after edge E(len+2). Results are held stable from DONE until the next accepted start.
- start while busy or in DONE is ignored and not queued.
- Runs back-to-back are allowed: start held high in IDLE launches a new run immediately.
- Reset mid-run: everything returns to reset values at once. det_rst_n = 0 also resets the detector.
- pattern and len changing during a run have no effect.
- All outputs are registered or decoded from the state register only; there are no combinational paths from inputs to outputs.

Test Plan:
- len=4, pattern=16'h000B (1011): det_x sequence 1,0,1,1,0 → done 6 cycles after start edge, match_cnt=1, first_idx=4.
- len=8, pattern=16'h00BB (10111011): two non-overlapping matches → match_cnt=2, first_idx=4; second z is observed in DRAIN.
- len=16, pattern=16'hBBBB → match_cnt=4; rebuild with CNT_W=2 → match_cnt=3 (saturated). len=31 behaves identically to 16.
- len=4, pattern=16'h0005 (0101) → match_cnt=0, first_idx=0; len=0 → CLEAR, DRAIN, DONE with done 2 cycles after the start edge, counts 0.
- start re-pulsed mid-SHIFT → ignored, results unchanged. start held high → a second run begins the cycle after DONE and clears the results on entry to CLEAR.
- reset_n low during SHIFT of the 16'hBBBB run → all outputs go to reset values immediately with det_rst_n=0; after release, a new len=4/0xB run gives match_cnt=1.

Source files
------------

// File: rtl/seqdet_driver.sv
// -----------------------------------------------------------------------------
// seqdet_driver
//
// Self-test sequencer for the lab board's serial "1011" sequence detector.
// A start request latches a pattern word and a bit count, pulses the
// detector's reset for one cycle, then shifts the pattern into the detector
// MSB-first, one bit per clock. One extra DRAIN cycle lets the registered match
// output caused by the last bit arrive. Match pulses are counted (saturating),
// and the bit position of the first match is recorded for the display logic.
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   start      in   run request, only honoured in IDLE
//   pattern    in   [PAT_W-1:0] bits [len-1:0] are shifted, bit len-1 first
//   len        in   [LEN_W-1:0] bits to shift; values above PAT_W clamp to PAT_W
//   det_z      in   detector match output
//   det_x      out  serial bit to the detector
//   det_rst_n  out  detector reset, active-low, registered
//   busy       out  high during CLEAR/SHIFT/DRAIN
//   done       out  one-cycle pulse in DONE
//   match_cnt  out  [CNT_W-1:0] match pulses seen in the last run, saturating
//   first_idx  out  [LEN_W-1:0] bits consumed when the first match was seen,
//                   0 when there was no match
//   state_out  out  [3:0] zero-padded FSM state code for the display
// -----------------------------------------------------------------------------
module seqdet_driver #(
   parameter int PAT_W = 16,
   parameter int LEN_W = 5,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   input  logic             det_z,
   output logic             det_x,
   output logic             det_rst_n,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] match_cnt,
   output logic [LEN_W-1:0] first_idx,
   output logic [3:0]       state_out
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      SHIFT = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state;
   state_t           state_nxt;
   logic [PAT_W-1:0] shreg;
   logic [LEN_W-1:0] len_lat;
   logic [LEN_W-1:0] len_clamp;
   logic [LEN_W-1:0] bit_cnt;
   logic             accept;
   logic             count_en;

   assign len_clamp = (len > PAT_W_L) ? PAT_W_L : len;
   assign accept    = (state == IDLE) && start;
   // det_z only matters while bits are in flight or the last result is draining
   assign count_en  = ((state == SHIFT) || (state == DRAIN)) && det_z;

   assign busy      = (state == CLEAR) || (state == SHIFT) || (state == DRAIN);
   assign done      = (state == DONE);
   assign state_out = {1'b0, state};

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = start ? CLEAR : IDLE;
         CLEAR:   state_nxt = (len_lat != '0) ? SHIFT : DRAIN;
         SHIFT:   state_nxt = (bit_cnt == len_lat - LEN_W'(1)) ? DRAIN : SHIFT;
         DRAIN:   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath and registered detector drive
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         det_x     <= 1'b0;
         det_rst_n <= 1'b0;
         shreg     <= '0;
         len_lat   <= '0;
         bit_cnt   <= '0;
         match_cnt <= '0;
         first_idx <= '0;
      end else begin
         // Detector is held in reset for exactly the CLEAR cycle
         det_rst_n <= (state_nxt != CLEAR);
         // The bit presented in each SHIFT cycle is loaded on the edge entering
         // that cycle, so the shift register pops its MSB whenever SHIFT is next
         det_x     <= (state_nxt == SHIFT) ? shreg[PAT_W-1] : 1'b0;

         if (accept) begin
            // Left-align the active bits so the first one to send is the MSB
            shreg     <= pattern << (PAT_W_L - len_clamp);
            len_lat   <= len_clamp;
            bit_cnt   <= '0;
            match_cnt <= '0;
            first_idx <= '0;
         end else begin
            if (state_nxt == SHIFT) begin
               shreg <= shreg << 1;
            end
            if (state == SHIFT) begin
               bit_cnt <= bit_cnt + LEN_W'(1);
            end
            if (count_en) begin
               if (match_cnt != CNT_MAX) begin
                  match_cnt <= match_cnt + CNT_W'(1);
               end
               // bit_cnt already equals the latched length by the DRAIN cycle
               if (first_idx == '0) begin
                  first_idx <= bit_cnt;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_seqdet_driver.sv
module tb_seqdet_driver;

   localparam int PAT_W   = 16;
   localparam int LEN_W   = 5;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             start = 1'b0;
   logic [PAT_W-1:0] pattern = '0;
   logic [LEN_W-1:0] len = '0;
   logic             det_z = 1'b0;
   logic             det_x;
   logic             det_rst_n;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] match_cnt;
   logic [LEN_W-1:0] first_idx;
   logic [3:0]       state_out;

   seqdet_driver #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .pattern   (pattern),
      .len       (len),
      .det_z     (det_z),
      .det_x     (det_x),
      .det_rst_n (det_rst_n),
      .busy      (busy),
      .done      (done),
      .match_cnt (match_cnt),
      .first_idx (first_idx),
      .state_out (state_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      int               n0;
      int               len;
      logic [PAT_W-1:0] pat;
      int               cnt;
      int               first;
   } exp_t;

   exp_t q[$];
   int   last_cnt   = 0;
   int   last_first = 0;
   bit   hold_chk   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // External "1011" detector, non-overlapping, registered z
   logic [3:0] win  = '0;
   int         dcnt = 0;
   always @(posedge clk) begin
      if (!det_rst_n) begin
         win   <= '0;
         dcnt  <= 0;
         det_z <= 1'b0;
      end else begin
         win <= {win[2:0], det_x};
         if (dcnt >= 3 && {win[2:0], det_x} == 4'b1011) begin
            det_z <= 1'b1;
            dcnt  <= 0;
         end else begin
            det_z <= 1'b0;
            dcnt  <= (dcnt < 4) ? dcnt + 1 : dcnt;
         end
      end
   end

   // Reference: greedy left-to-right scan of the bit string for "1011"
   function automatic void ref_model(input logic [PAT_W-1:0] p, input int l,
                                     output int cnt, output int first);
      int i;
      cnt = 0; first = 0; i = 0;
      while (i + 4 <= l) begin
         if (p[l-1-i] && !p[l-2-i] && p[l-3-i] && p[l-4-i]) begin
            cnt++;
            if (first == 0) first = i + 4;
            i += 4;
         end else begin
            i++;
         end
      end
      if (cnt > CNT_MAX) cnt = CNT_MAX;
   endfunction

   function automatic int clamp_len(input int l);
      return (l > PAT_W) ? PAT_W : l;
   endfunction

   function automatic exp_t make_exp(input int n0, input logic [PAT_W-1:0] p, input int l);
      exp_t e;
      e.n0  = n0;
      e.len = clamp_len(l);
      e.pat = p;
      ref_model(p, e.len, e.cnt, e.first);
      return e;
   endfunction

   // Monitor: checks the timeline of the run at the head of the queue
   exp_t mon_h;
   int   mon_d;
   always @(negedge clk) begin
      if (reset_n) begin
         if (q.size() > 0) begin
            mon_h = q[0];
            mon_d = cyc - mon_h.n0;
            if (mon_d == 0) begin
               check("clear_state", state_out, 1);
               check("clear_det_rst_n", det_rst_n, 0);
               check("clear_busy", busy, 1);
               check("clear_results", {match_cnt, first_idx}, 0);
            end else if (mon_d >= 1 && mon_d <= mon_h.len) begin
               check("shift_det_x", det_x, mon_h.pat[mon_h.len - mon_d]);
               check("shift_det_rst_n", det_rst_n, 1);
               check("shift_state", state_out, 2);
            end else if (mon_d == mon_h.len + 1) begin
               check("drain_det_x", det_x, 0);
               check("drain_state", state_out, 3);
               check("drain_done_low", done, 0);
            end else if (mon_d >= mon_h.len + 2) begin
               check("done_pulse", done, 1);
               check("done_busy", busy, 0);
               check("match_cnt", match_cnt, mon_h.cnt);
               check("first_idx", first_idx, mon_h.first);
               last_cnt   = mon_h.cnt;
               last_first = mon_h.first;
               void'(q.pop_front());
            end
         end else if (hold_chk) begin
            check("idle_done_low", done, 0);
            check("hold_match_cnt", match_cnt, last_cnt);
            check("hold_first_idx", first_idx, last_first);
         end
      end
   end

   task automatic wait_empty();
      int guard = 0;
      while (q.size() != 0 && guard < 300) begin
         @(posedge clk);
         guard++;
      end
      check("queue_drain", q.size(), 0);
   endtask

   // One run; poke_at >= 0 re-pulses start that many cycles after CLEAR
   task automatic run(input logic [PAT_W-1:0] p, input int l, input int poke_at);
      int n0;
      int lc;
      wait_empty();
      @(negedge clk);
      pattern = p;
      len     = LEN_W'(l);
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n0    = cyc;
      lc    = clamp_len(l);
      q.push_back(make_exp(n0, p, l));
      pattern = PAT_W'($urandom);
      len     = LEN_W'($urandom);
      if (poke_at >= 0 && poke_at <= lc + 2) begin
         @(negedge clk);
         repeat (poke_at) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   // Two runs launched by one held start; second run's inputs change mid-first-run
   task automatic run_b2b(input logic [PAT_W-1:0] pa, input int la,
                          input logic [PAT_W-1:0] pb, input int lb);
      int n0;
      int n0b;
      int guard;
      wait_empty();
      @(negedge clk);
      pattern = pa;
      len     = LEN_W'(la);
      start   = 1'b1;
      @(posedge clk);
      #1;
      n0 = cyc;
      q.push_back(make_exp(n0, pa, la));
      pattern = pb;
      len     = LEN_W'(lb);
      n0b = n0 + clamp_len(la) + 4;
      q.push_back(make_exp(n0b, pb, lb));
      guard = 0;
      while (cyc < n0b && guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
      end
      start = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [PAT_W-1:0] rp;
      int               rl;
      int               rpk;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_det_x", det_x, 0);
      check("rst_det_rst_n", det_rst_n, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_match_cnt", match_cnt, 0);
      check("rst_first_idx", first_idx, 0);
      check("rst_state", state_out, 0);
      @(negedge clk);
      reset_n    = 1'b1;
      last_cnt   = 0;
      last_first = 0;
      hold_chk   = 1'b1;

      // Directed runs
      run(16'h000B, 4, -1);
      run(16'h00BB, 8, -1);
      run(16'hBBBB, 16, -1);
      run(16'hBBBB, 31, -1);
      run(16'h0005, 4, -1);
      run(16'hFFFF, 0, -1);
      run(16'hBBBB, 16, 5);
      run_b2b(16'h00BB, 8, 16'h000B, 4);
      run_b2b(16'h1234, 0, 16'hB0B0, 16);

      // Randomized runs
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            for (int j = 0; j < 4; j++) begin
               rp[j*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hB;
            end
         end else begin
            rp = PAT_W'($urandom);
         end
         rl  = $urandom_range(0, 31);
         rpk = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 18) : -1;
         repeat ($urandom_range(0, 3)) @(posedge clk);
         run(rp, rl, rpk);
      end

      // Reset in the middle of a SHIFT
      wait_empty();
      @(negedge clk);
      hold_chk = 1'b0;
      pattern  = 16'hBBBB;
      len      = 5'd16;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check("mid_rst_det_x", det_x, 0);
      check("mid_rst_det_rst_n", det_rst_n, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_match_cnt", match_cnt, 0);
      check("mid_rst_first_idx", first_idx, 0);
      check("mid_rst_state", state_out, 0);
      last_cnt   = 0;
      last_first = 0;
      @(negedge clk);
      reset_n  = 1'b1;
      hold_chk = 1'b1;
      run(16'h000B, 4, -1);

      wait_empty();
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
